// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: run-time loadable word memory, program counter,
// next-PC selection (sequential / branch / jump) and halt / fault detection.
module instr_fetch_unit #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF,
    parameter int          COUNT_W     = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           stall,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [31:0]                    load_data,
    input  logic                           branch_taken,
    input  logic [15:0]                    branch_offset,
    input  logic                           jump_en,
    input  logic [25:0]                    jump_index,
    output logic [31:0]                    pc,
    output logic [31:0]                    pc_plus4,
    output logic [31:0]                    instr,
    output logic                           instr_valid,
    output logic                           halted,
    output logic                           fault,
    output logic [COUNT_W-1:0]             instr_count
);

    localparam int          ADDR_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LAST_ADDR = 32'(4 * DEPTH_WORDS - 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED,
        S_FAULT
    } state_t;

    state_t             state;
    logic [31:0]        mem [DEPTH_WORDS];
    logic [ADDR_W-1:0]  rd_idx;
    logic [31:0]        rd_word;
    logic               pc_legal;
    logic               mem_write;
    logic [31:0]        branch_disp;
    logic [31:0]        next_pc;

    // A word is only fetched from memory when pc is aligned and in range,
    // so the array is never indexed past its last entry.
    assign pc_plus4    = pc + 32'd4;
    assign pc_legal    = (pc[1:0] == 2'b00) && (pc <= LAST_ADDR);
    assign rd_idx      = pc[ADDR_W+1:2];
    assign rd_word     = mem[rd_idx];
    assign instr       = pc_legal ? rd_word : HALT_WORD;
    assign instr_valid = (state == S_RUN) && pc_legal;

    assign branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump_en) begin
            next_pc = {pc_plus4[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_disp;
        end
    end

    // Program image may only change while not running; reset drops loads.
    assign mem_write = load_en && !reset && (state != S_RUN)
                       && ({1'b0, load_addr} < (ADDR_W+1)'(DEPTH_WORDS));

    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr_count <= '0;
            halted      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALTED, S_FAULT: begin
                    if (start) begin
                        state       <= S_RUN;
                        pc          <= RESET_PC;
                        instr_count <= '0;
                        halted      <= 1'b0;
                        fault       <= 1'b0;
                    end
                end
                S_RUN: begin
                    // An illegal pc faults even while stalled; pc stays put
                    // so the offending address remains visible.
                    if (!pc_legal) begin
                        state <= S_FAULT;
                        fault <= 1'b1;
                    end else if (!stall) begin
                        if (rd_word == HALT_WORD) begin
                            state  <= S_HALTED;
                            halted <= 1'b1;
                        end else begin
                            pc          <= next_pc;
                            instr_count <= instr_count + COUNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, self-checking bench for instr_fetch_unit with default parameters.
module tb_instr_fetch_unit;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stall;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump_en;
    logic [25:0] jump_index;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        halted;
    logic        fault;
    logic [31:0] instr_count;

    int checks;
    int failures;

    instr_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stall        (stall),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump_en      (jump_en),
        .jump_index   (jump_index),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .halted       (halted),
        .fault        (fault),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; stall = 0; load_en = 0; load_addr = '0; load_data = '0;
        branch_taken = 0; branch_offset = '0; jump_en = 0; jump_index = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic load_word(input logic [5:0] a, input logic [31:0] d);
        load_en = 1; load_addr = a; load_data = d;
        step();
        load_en = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        step();
        start = 0;
    endtask

    task automatic test_reset();
        checks++; if (pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        checks++; if (pc_plus4 !== 32'h4) begin failures++; $display("[TB] FAIL reset_pc_plus4: got %h expected %h", pc_plus4, 32'h4); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (fault !== 1'b0) begin failures++; $display("[TB] FAIL reset_fault: got %b expected 0", fault); end
        checks++; if (instr_count !== 32'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", instr_count); end
    endtask

    // Reset asserted together with start and a load: reset wins, load is dropped.
    task automatic test_reset_priority();
        reset = 1; start = 1; load_en = 1; load_addr = 6'd5; load_data = 32'hDEAD_BEEF;
        step();
        clear_inputs();
        reset = 0;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstprio_valid: got %b expected 0", instr_valid); end
        checks++; if (pc !== 32'h0) begin failures++; $display("[TB] FAIL rstprio_pc: got %h expected %h", pc, 32'h0); end
        step();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstprio_idle: got %b expected 0", instr_valid); end
    endtask

    task automatic test_program();
        load_word(6'd0, 32'h0000_0022);
        load_word(6'd1, 32'h8C01_0000);
        load_word(6'd2, 32'h8C02_0004);
        load_word(6'd3, HALT);
        checks++; if (instr !== 32'h0000_0022) begin failures++; $display("[TB] FAIL prog_preview: got %h expected %h", instr, 32'h0000_0022); end
        pulse_start();
        checks++; if (pc !== 32'h0 || instr_valid !== 1'b1) begin failures++; $display("[TB] FAIL prog_pc0: got pc=%h v=%b expected pc=0 v=1", pc, instr_valid); end
        checks++; if (instr !== 32'h0000_0022) begin failures++; $display("[TB] FAIL prog_instr0: got %h expected %h", instr, 32'h0000_0022); end
        step();
        checks++; if (pc !== 32'h4 || instr !== 32'h8C01_0000) begin failures++; $display("[TB] FAIL prog_pc4: got pc=%h instr=%h expected pc=4 instr=8c010000", pc, instr); end
        checks++; if (instr_count !== 32'd1) begin failures++; $display("[TB] FAIL prog_count1: got %0d expected 1", instr_count); end
        step();
        checks++; if (pc !== 32'h8 || instr !== 32'h8C02_0004) begin failures++; $display("[TB] FAIL prog_pc8: got pc=%h instr=%h expected pc=8 instr=8c020004", pc, instr); end
        step();
        checks++; if (pc !== 32'hC || instr !== HALT) begin failures++; $display("[TB] FAIL prog_pc12: got pc=%h instr=%h expected pc=c instr=ffffffff", pc, instr); end
        checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL prog_not_yet_halted: got %b expected 0", halted); end
        step();
        checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL prog_halted: got %b expected 1", halted); end
        checks++; if (instr_count !== 32'd3) begin failures++; $display("[TB] FAIL prog_count3: got %0d expected 3", instr_count); end
        checks++; if (pc !== 32'hC) begin failures++; $display("[TB] FAIL prog_pc_held: got %h expected %h", pc, 32'hC); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL prog_halt_valid: got %b expected 0", instr_valid); end
        step();
        checks++; if (halted !== 1'b1 || pc !== 32'hC) begin failures++; $display("[TB] FAIL prog_halt_stays: got h=%b pc=%h expected h=1 pc=c", halted, pc); end
    endtask

    // From HALTED: load and start in the same cycle; the new word is fetched first.
    task automatic test_load_with_start();
        load_en = 1; load_addr = 6'd0; load_data = 32'h1111_1111; start = 1;
        step();
        clear_inputs();
        checks++; if (instr !== 32'h1111_1111 || instr_valid !== 1'b1) begin failures++; $display("[TB] FAIL ldstart_instr: got %h v=%b expected 11111111 v=1", instr, instr_valid); end
        checks++; if (halted !== 1'b0 || instr_count !== 32'd0) begin failures++; $display("[TB] FAIL ldstart_state: got h=%b cnt=%0d expected h=0 cnt=0", halted, instr_count); end
        do_reset();
        load_word(6'd0, 32'h0000_0022);
    endtask

    task automatic test_branch();
        pulse_start();
        jump_en = 1; jump_index = 26'd8;
        step();
        clear_inputs();
        checks++; if (pc !== 32'h20) begin failures++; $display("[TB] FAIL br_setup: got %h expected %h", pc, 32'h20); end
        stall = 1; branch_taken = 1; branch_offset = 16'h0003;
        step();
        checks++; if (pc !== 32'h20 || instr_count !== 32'd1) begin failures++; $display("[TB] FAIL br_stall_ignored: got pc=%h cnt=%0d expected pc=20 cnt=1", pc, instr_count); end
        stall = 0;
        step();
        clear_inputs();
        checks++; if (pc !== 32'h30) begin failures++; $display("[TB] FAIL br_fwd: got %h expected %h", pc, 32'h30); end
        jump_en = 1; jump_index = 26'd8;
        step();
        clear_inputs();
        branch_taken = 1; branch_offset = 16'hFFFA;
        step();
        clear_inputs();
        checks++; if (pc !== 32'hC) begin failures++; $display("[TB] FAIL br_back: got %h expected %h", pc, 32'hC); end
        checks++; if (instr_count !== 32'd4) begin failures++; $display("[TB] FAIL br_count: got %0d expected 4", instr_count); end
        step();
        checks++; if (halted !== 1'b1 || instr_count !== 32'd4) begin failures++; $display("[TB] FAIL br_halt: got h=%b cnt=%0d expected h=1 cnt=4", halted, instr_count); end
    endtask

    task automatic test_jump();
        pulse_start();
        jump_en = 1; jump_index = 26'd4;
        step();
        checks++; if (pc !== 32'h10) begin failures++; $display("[TB] FAIL jmp_first: got %h expected %h", pc, 32'h10); end
        jump_index = 26'd5; branch_taken = 1; branch_offset = 16'h0003;
        step();
        clear_inputs();
        checks++; if (pc !== 32'h14) begin failures++; $display("[TB] FAIL jmp_wins: got %h expected %h", pc, 32'h14); end
        checks++; if (instr !== 32'h0) begin failures++; $display("[TB] FAIL jmp_dropped_load: got %h expected %h", instr, 32'h0); end
        checks++; if (pc_plus4 !== 32'h18) begin failures++; $display("[TB] FAIL jmp_pc_plus4: got %h expected %h", pc_plus4, 32'h18); end
        do_reset();
    endtask

    task automatic test_fault();
        pulse_start();
        jump_en = 1; jump_index = 26'd63;
        step();
        clear_inputs();
        checks++; if (pc !== 32'hFC || instr_valid !== 1'b1) begin failures++; $display("[TB] FAIL flt_last: got pc=%h v=%b expected pc=fc v=1", pc, instr_valid); end
        branch_taken = 1; branch_offset = 16'h0000;
        step();
        clear_inputs();
        checks++; if (pc !== 32'h100) begin failures++; $display("[TB] FAIL flt_pc: got %h expected %h", pc, 32'h100); end
        checks++; if (instr_valid !== 1'b0 || instr !== HALT) begin failures++; $display("[TB] FAIL flt_invalid: got v=%b instr=%h expected v=0 instr=ffffffff", instr_valid, instr); end
        checks++; if (fault !== 1'b0) begin failures++; $display("[TB] FAIL flt_early: got %b expected 0", fault); end
        stall = 1;
        step();
        stall = 0;
        checks++; if (fault !== 1'b1 || pc !== 32'h100) begin failures++; $display("[TB] FAIL flt_set: got f=%b pc=%h expected f=1 pc=100", fault, pc); end
        checks++; if (instr_count !== 32'd2) begin failures++; $display("[TB] FAIL flt_count: got %0d expected 2", instr_count); end
        pulse_start();
        checks++; if (fault !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b1) begin failures++; $display("[TB] FAIL flt_restart: got f=%b pc=%h v=%b expected f=0 pc=0 v=1", fault, pc, instr_valid); end
        do_reset();
    endtask

    task automatic test_stall();
        pulse_start();
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pc !== 32'h4 || instr_count !== 32'd1 || instr_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_hold%0d: got pc=%h cnt=%0d v=%b expected pc=4 cnt=1 v=1", i, pc, instr_count, instr_valid); end
        end
        stall = 0;
        step();
        checks++; if (pc !== 32'h8 || instr_count !== 32'd2) begin failures++; $display("[TB] FAIL stall_resume: got pc=%h cnt=%0d expected pc=8 cnt=2", pc, instr_count); end
        step();
        stall = 1;
        step();
        step();
        checks++; if (halted !== 1'b0 || pc !== 32'hC || instr_count !== 32'd3) begin failures++; $display("[TB] FAIL stall_halt_delay: got h=%b pc=%h cnt=%0d expected h=0 pc=c cnt=3", halted, pc, instr_count); end
        stall = 0;
        step();
        checks++; if (halted !== 1'b1 || instr_count !== 32'd3) begin failures++; $display("[TB] FAIL stall_halt_release: got h=%b cnt=%0d expected h=1 cnt=3", halted, instr_count); end
    endtask

    task automatic test_run_load_and_reset();
        pulse_start();
        load_en = 1; load_addr = 6'd1; load_data = 32'hA5A5_A5A5;
        step();
        load_en = 0;
        checks++; if (instr !== 32'h8C01_0000) begin failures++; $display("[TB] FAIL runload_ignored: got %h expected %h", instr, 32'h8C01_0000); end
        step();
        checks++; if (pc !== 32'h8) begin failures++; $display("[TB] FAIL runrst_at8: got %h expected %h", pc, 32'h8); end
        reset = 1;
        step();
        reset = 0;
        checks++; if (pc !== 32'h0 || instr_count !== 32'd0 || instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL runrst_idle: got pc=%h cnt=%0d v=%b expected pc=0 cnt=0 v=0", pc, instr_count, instr_valid); end
        pulse_start();
        checks++; if (instr !== 32'h0000_0022 || instr_valid !== 1'b1) begin failures++; $display("[TB] FAIL rerun_0: got %h v=%b expected 00000022 v=1", instr, instr_valid); end
        step();
        step();
        checks++; if (pc !== 32'h8 || instr !== 32'h8C02_0004) begin failures++; $display("[TB] FAIL rerun_8: got pc=%h instr=%h expected pc=8 instr=8c020004", pc, instr); end
        step();
        step();
        checks++; if (halted !== 1'b1 || instr_count !== 32'd3 || pc !== 32'hC) begin failures++; $display("[TB] FAIL rerun_halt: got h=%b cnt=%0d pc=%h expected h=1 cnt=3 pc=c", halted, instr_count, pc); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        test_reset();
        for (int i = 0; i < 64; i++) begin
            load_word(6'(i), 32'h0);
        end
        test_reset_priority();
        test_program();
        test_load_with_start();
        test_branch();
        test_jump();
        test_fault();
        test_stall();
        test_run_load_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Parametrised, clocked instruction-fetch stage for the MIPS single-cycle datapath. It holds a loadable, byte-addressed, big-endian instruction memory and owns the program counter. It also computes next-PC from sequential, branch and jump inputs, and detects halt and fetch faults. It sits in front of decode/register-file and replaces hard-coded program storage with a run-time loadable program image.

## Interface
- DEPTH_WORDS, 64: instruction memory depth in 32-bit words (byte span 4*DEPTH_WORDS).
- RESET_PC, 32'h0: PC value on reset and on start.
- HALT_WORD, 32'hFFFFFFFF: encoding treated as halt.
- COUNT_W, 32: width of retired-instruction counter.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: begin execution at RESET_PC (honoured in IDLE/HALTED/FAULT).
- stall  in  1  hold PC and counter this cycle.
- load_en  in  1  write one word into instruction memory.
- load_addr  in  clog2(DEPTH_WORDS)  word index for load.
- load_data  in  32  word to store (bits 31:24 at lowest byte address).
- branch_taken  in  1  take PC-relative branch this cycle.
- branch_offset  in  16  signed word offset (instr[15:0]).
- jump_en  in  1  take absolute jump this cycle.
- jump_index  in  26  jump field (instr[25:0]).
- pc  out  32  current fetch address.
- pc_plus4  out  32  pc + 4.
- instr  out  32  word at pc (combinational read).
- instr_valid  out  1  high in RUN when pc is legal.
- halted  out  1  state == HALTED.
- fault  out  1  state == FAULT.
- instr_count  out  COUNT_W  retired instructions since last start.

## Operation
- States: IDLE (reset), RUN, HALTED, FAULT.
- IDLE/HALTED/FAULT: load_en writes mem[load_addr] = load_data; start -> RUN, pc <= RESET_PC, instr_count <= 0. load_en and start together: write and enter RUN in the same cycle.
- RUN: load_en ignored; start ignored.
- Legal pc: pc[1:0] == 0 and pc <= 4*DEPTH_WORDS-4. In RUN with illegal pc: instr_valid=0, instr=HALT_WORD, next state FAULT (regardless of stall), pc held.
- RUN, legal, instr == HALT_WORD, !stall: next state HALTED, pc held, count not incremented.
- RUN, legal, non-halt, !stall: pc <= next_pc, instr_count += 1 (wraps mod 2^COUNT_W).
- next_pc priority: jump_en -> {pc_plus4[31:28], jump_index, 2'b00}; else branch_taken -> pc_plus4 + {sext(branch_offset),2'b00} (mod 2^32); else pc_plus4.
- stall in RUN: pc, count, state held; instr_valid still reflects legality.
- Memory not cleared by reset; read out-of-range never indexes beyond array.

## Timing
- Reset values: state IDLE, pc=RESET_PC, pc_plus4=RESET_PC+4, instr_valid=0, halted=0, fault=0, instr_count=0.
- reset wins over start/load_en in the same cycle; loads during that cycle are dropped.
- instr and pc_plus4 combinational from pc; zero-latency read of loaded data one cycle after the write edge.
- start edge -> first instruction visible cycle+1 with instr_valid=1.
- PC update, count, state transitions all on rising clk edge.
- reset mid-RUN: next cycle IDLE, pc=RESET_PC, memory intact; start re-runs the program.
- branch_taken/jump_en sampled only in RUN with instr_valid and !stall; otherwise ignored.

## Test plan
- Load 4 words (0x00000022, 0x8C010000, 0x8C020004, HALT_WORD) at indices 0-3, start -> pc 0,4,8,12 on successive cycles, then halted=1, instr_count=3, pc=12.
- At pc=0x20 assert branch_taken with offset 16'hFFFA -> next pc=0x0C; with offset 0x0003 -> next pc=0x30.
- jump_en with jump_index=0x0000005 at pc=0x10 -> next pc=0x14; jump_en and branch_taken together -> jump target wins.
- Branch to pc=4*DEPTH_WORDS (0x100 default) -> instr_valid=0 that cycle, fault=1 next, pc held; start clears to RUN at 0.
- Stall 3 cycles mid-program -> pc and count frozen, resume identical sequence; stall on HALT_WORD delays halt until released.
- load_en during RUN -> memory unchanged; reset during RUN at pc=8 -> IDLE, pc=0, count=0, restart reproduces original sequence.
